// File: rtl/main_mem_pkg.sv
// Shared types and default constants for the main-memory controller.
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_W         = 32;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_LATENCY        = 8;
    localparam int unsigned DEF_LINE_WORDS     = 4;
    localparam int unsigned DEF_MEM_DEPTH_LOG2 = 12;

    // Latency counter must hold LATENCY-1 for the largest legal LATENCY (255)
    localparam int unsigned MAX_LATENCY = 255;
    localparam int unsigned CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/main_mem_if.sv
// Strobe/acknowledge request bus between the L2 cache (master) and main memory (slave).
interface main_mem_if
    import main_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              last;
    logic              busy;

    modport master (
        output stb, we, addr, wdata,
        input  rdata, ack, last, busy
    );

    modport slave (
        input  stb, we, addr, wdata,
        output rdata, ack, last, busy
    );
endinterface

// File: rtl/main_mem_array.sv
// Synchronous single-port word RAM; only the read-data register is reset, never the storage.
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned AW     = DEF_MEM_DEPTH_LOG2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_en && !i_we) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller: fixed-latency single-request service of L2 misses and write-backs.
// MAIN_MEM_BURST_EN selects a wrap-around critical-word-first line burst on reads.
module main_mem_ctrl
    import main_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned MEM_DEPTH_LOG2 = DEF_MEM_DEPTH_LOG2,
    parameter int unsigned LATENCY        = DEF_LATENCY,
    parameter int unsigned LINE_WORDS     = DEF_LINE_WORDS
) (
    input  logic       clk,
    input  logic       reset,
    main_mem_if.slave  bus
);
    localparam int unsigned AW = MEM_DEPTH_LOG2;
    localparam int unsigned LB = $clog2(LINE_WORDS);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LB-1:0]     r_beat;
    logic [AW-1:0]     r_widx;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ack;
    logic              r_last;
    logic              r_busy;

    logic              w_last_beat;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [AW-1:0]     w_ram_addr;
    logic [DATA_W-1:0] w_ram_q;
    logic              w_unused_addr;

`ifdef MAIN_MEM_BURST_EN
    assign w_last_beat = r_we || (r_beat == LB'(LINE_WORDS - 1));
`else
    assign w_last_beat = 1'b1;
`endif

    // RAM access happens in the XFER cycle so its result lands together with ack
    assign w_ram_en   = (r_state == XFER) && !reset;
    assign w_ram_we   = w_ram_en && r_we;
    assign w_ram_addr = {r_widx[AW-1:LB], LB'(r_widx[LB-1:0] + r_beat)};

    assign w_unused_addr = ^{bus.addr[ADDR_W-1:AW+2], bus.addr[1:0]};

    main_mem_array #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_array (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_widx  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_last <= 1'b0;
            r_busy <= (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (bus.stb) begin
                        r_widx  <= bus.addr[AW+1:2];
                        r_we    <= bus.we;
                        r_wdata <= bus.wdata;
                        r_beat  <= '0;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_state <= (LATENCY == 1) ? XFER : WAIT;
                    end
                end
                WAIT: begin
                    // XFER must start one cycle before the first ack is due
                    if (r_cnt <= CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= XFER;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                XFER: begin
                    r_ack  <= 1'b1;
                    r_last <= w_last_beat;
                    r_beat <= r_beat + LB'(1);
                    if (w_last_beat) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rdata = w_ram_q;
    assign bus.ack   = r_ack;
    assign bus.last  = r_last;
    assign bus.busy  = r_busy;

endmodule
